// File: rtl/spi_note_sender_pkg.sv
// Shared definitions for the note-packet SPI sender.
//   PACKET_SIZE  : bits in one track packet (16-bit tuneWord + 8-bit volume)
//   packetType   : one track packet, tuneWord in [23:8], volume in [7:0]
//   sender_state_e : sender FSM states
//   FRAME_BITS() : total serial bits in a frame for a given track count
package spi_note_sender_pkg;

  localparam int PACKET_SIZE = 24;

  typedef logic [PACKET_SIZE-1:0] packetType;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } sender_state_e;

  function automatic int FRAME_BITS(input int num_tracks);
    return num_tracks * PACKET_SIZE;
  endfunction

endpackage

// File: rtl/spi_note_sender_sck_phase_timer.sv
// Reloadable down-counter that times one sck phase (or the chip-select gap).
//   clk, reset  : system clock, asynchronous active-high reset
//   load        : start a new phase this cycle
//   load_cycles : length of the new phase in clk cycles (must be >= 1)
//   phase_end   : high during the last cycle of the current phase
module sck_phase_timer
  import spi_note_sender_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_cycles,
  output logic             phase_end
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // The count holds the cycles remaining after the current one, so a
  // one-cycle phase loads 0 and ends immediately.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_cycles - WIDTH'(1);
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase_end = (count_q == '0);

endmodule

// File: rtl/spi_note_sender.sv
// SPI master that serialises NUM_TRACKS note packets per frame for the
// note-player SPI receiver.
//   clk, reset   : system clock, asynchronous active-high reset
//   start        : frame request, sampled only while idle (also in the done cycle)
//   notePackets  : packet array, index NUM_TRACKS-1 is sent first, MSB first
//   busy         : high while a frame (including the trailing gap) is in progress
//   done         : one-cycle pulse in the first idle cycle after a frame
//   chipSelect   : active-high frame enable
//   sck          : serial clock, idle low, receiver samples on the rising edge
//   sdi          : serial data
// All outputs come straight from flops so sck is glitch-free.
module spi_note_sender
  import spi_note_sender_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  packetType [NUM_TRACKS-1:0]  notePackets,
  output logic                        busy,
  output logic                        done,
  output logic                        chipSelect,
  output logic                        sck,
  output logic                        sdi
);

  localparam int N         = FRAME_BITS(NUM_TRACKS);
  localparam int BIT_W     = $clog2(N + 1);
  localparam int MAX_PHASE = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int PHASE_W   = $clog2(MAX_PHASE + 1);

  localparam logic [PHASE_W-1:0] DIV_CYCLES = PHASE_W'(CLK_DIV);
  // The done cycle is itself a chip-select-low cycle, so the GAP state lasts
  // one cycle less than CS_GAP. Back-to-back frames are then separated by
  // exactly CS_GAP low cycles.
  localparam logic [PHASE_W-1:0] GAP_CYCLES = PHASE_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(N - 1);

  sender_state_e        state_q, state_d;
  logic [N-1:0]         shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 cs_q, cs_d;
  logic                 sck_q, sck_d;
  logic                 sdi_q, sdi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [N-1:0]         frame_in;
  logic                 phase_load;
  logic [PHASE_W-1:0]   phase_cycles;
  logic                 phase_end;

  assign frame_in = notePackets;

  sck_phase_timer #(
    .WIDTH (PHASE_W)
  ) u_phase_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (phase_load),
    .load_cycles (phase_cycles),
    .phase_end   (phase_end)
  );

  // Next-state and next-output logic. Every output is the registered copy of
  // its _d value, so each transition computes what the pins show next cycle.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    cs_d         = cs_q;
    sck_d        = sck_q;
    sdi_d        = sdi_q;
    done_d       = 1'b0;
    phase_load   = 1'b0;
    phase_cycles = DIV_CYCLES;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = frame_in;
          bit_cnt_d  = '0;
          cs_d       = 1'b1;
          sck_d      = 1'b0;
          sdi_d      = frame_in[N-1];
          state_d    = SETUP;
          phase_load = 1'b1;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sck_d      = 1'b1;
          state_d    = HIGH;
          phase_load = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d      = 1'b0;
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          phase_load = 1'b1;
          if (bit_cnt_q != LAST_BIT) begin
            // Next bit changes on the same edge that drops sck.
            shift_d = shift_q << 1;
            sdi_d   = shift_q[N-2];
            state_d = LOW;
          end else begin
            state_d = HOLD;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          sck_d      = 1'b1;
          state_d    = HIGH;
          phase_load = 1'b1;
        end
      end
      HOLD: begin
        if (phase_end) begin
          cs_d         = 1'b0;
          sdi_d        = 1'b0;
          state_d      = GAP;
          phase_load   = 1'b1;
          phase_cycles = GAP_CYCLES;
        end
      end
      GAP: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cs_q      <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign chipSelect = cs_q;
  assign sck        = sck_q;
  assign sdi        = sdi_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
